// File: rtl/pid_sequencer.sv
// PID steering sequencer: one shared signed multiplier computes the P and D terms, then a SUM state
// produces clamped left/right speeds. Define PID_I_TERM_EN to include the integral path (I_CALC, integ).
module pid_sequencer #(
   parameter logic signed [5:0]  P_COEFF  = 6'sd2,
   parameter logic signed [5:0]  D_COEFF  = 6'sd7,
   parameter logic        [11:0] BASE_SPD = 12'h200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        go,
   input  logic        err_vld,
   input  logic [15:0] error,
   output logic        busy,
   output logic        dropped,
   output logic        spd_vld,
   output logic [11:0] lft_spd,
   output logic [11:0] rght_spd
);
   localparam int unsigned ERR_W  = 11;
   localparam int unsigned DIFF_W = 9;
   localparam int unsigned TERM_W = 15;
   localparam int unsigned PROD_W = 17;
   localparam int unsigned ADJ_W  = 12;
   localparam int unsigned RAW_W  = 14;

   typedef enum logic [2:0] {
      IDLE, P_CALC, D_CALC, SUM
`ifdef PID_I_TERM_EN
      , I_CALC
`endif
   } state_t;

   function automatic logic signed [ERR_W-1:0] sat_err(input logic signed [15:0] x);
      if (x > 16'sd1023)  return 11'h3FF;
      if (x < -16'sd1024) return 11'h400;
      return x[ERR_W-1:0];
   endfunction

   function automatic logic signed [DIFF_W-1:0] sat_diff(input logic signed [11:0] x);
      if (x > 12'sd255)  return 9'h0FF;
      if (x < -12'sd256) return 9'h100;
      return x[DIFF_W-1:0];
   endfunction

   function automatic logic signed [TERM_W-1:0] sat_term(input logic signed [PROD_W-1:0] x);
      if (x > 17'sd16383)  return 15'h3FFF;
      if (x < -17'sd16384) return 15'h4000;
      return x[TERM_W-1:0];
   endfunction

   function automatic logic [11:0] clamp_spd(input logic signed [RAW_W-1:0] x);
      if (x < 14'sd0)    return 12'h000;
      if (x > 14'sd4095) return 12'hFFF;
      return x[11:0];
   endfunction

   state_t state, next_state;
   logic signed [ERR_W-1:0]  err_sat, prev_err, mul_a;
   logic signed [5:0]        mul_b;
   logic signed [PROD_W-1:0] prod, pid_raw;
   logic signed [TERM_W-1:0] p_term, d_term, pid_sat;
   logic signed [11:0]       diff_raw;
   logic signed [DIFF_W-1:0] diff_sat;
   logic signed [ADJ_W-1:0]  i_term, adj;
   logic signed [RAW_W-1:0]  lft_raw, rght_raw;
   logic ld_err, ld_p, ld_i, ld_d, ld_sum, sel_d;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state logic; go low aborts from any state
   always_comb begin
      next_state = state;
      if (!go) next_state = IDLE;
      else begin
         case (state)
            IDLE:    if (err_vld) next_state = P_CALC;
`ifdef PID_I_TERM_EN
            P_CALC:  next_state = I_CALC;
            I_CALC:  next_state = D_CALC;
`else
            P_CALC:  next_state = D_CALC;
`endif
            D_CALC:  next_state = SUM;
            SUM:     next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   // Per-state datapath controls
   always_comb begin
      ld_err = 1'b0;
      ld_p   = 1'b0;
      ld_i   = 1'b0;
      ld_d   = 1'b0;
      ld_sum = 1'b0;
      sel_d  = 1'b0;
      case (state)
         IDLE:    ld_err = err_vld;
         P_CALC:  ld_p = 1'b1;
`ifdef PID_I_TERM_EN
         I_CALC:  ld_i = 1'b1;
`endif
         D_CALC:  begin ld_d = 1'b1; sel_d = 1'b1; end
         SUM:     ld_sum = 1'b1;
         default: ;
      endcase
   end

   assign dropped = err_vld & busy;

   // Shared multiplier: (err_sat, P_COEFF) or (diff_sat, D_COEFF)
   assign diff_raw = $signed({err_sat[ERR_W-1], err_sat}) - $signed({prev_err[ERR_W-1], prev_err});
   assign diff_sat = sat_diff(diff_raw);
   assign mul_a    = sel_d ? $signed({{2{diff_sat[DIFF_W-1]}}, diff_sat}) : err_sat;
   assign mul_b    = sel_d ? D_COEFF : P_COEFF;
   assign prod     = $signed({{6{mul_a[ERR_W-1]}}, mul_a}) * $signed({{11{mul_b[5]}}, mul_b});

`ifdef PID_I_TERM_EN
   logic signed [15:0] integ;
   logic signed [16:0] integ_sum;
   logic signed [15:0] integ_sat;
   assign integ_sum = $signed({integ[15], integ}) + $signed({{6{err_sat[ERR_W-1]}}, err_sat});
   assign integ_sat = (integ_sum > 17'sd32767) ? 16'sh7FFF :
                      (integ_sum < -17'sd32768) ? 16'sh8000 : integ_sum[15:0];
   assign i_term    = integ[15:4];

   // Integrator accumulates only in I_CALC and clears on abort
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        integ <= '0;
      else if (!go)   integ <= '0;
      else if (ld_i)  integ <= integ_sat;
   end
`else
   assign i_term = '0;
`endif

   assign pid_raw  = $signed({{2{p_term[TERM_W-1]}}, p_term}) + $signed({{5{i_term[ADJ_W-1]}}, i_term})
                   + $signed({{2{d_term[TERM_W-1]}}, d_term});
   assign pid_sat  = sat_term(pid_raw);
   assign adj      = pid_sat[TERM_W-1:3];
   assign lft_raw  = $signed({2'b00, BASE_SPD}) + $signed({{2{adj[ADJ_W-1]}}, adj});
   assign rght_raw = $signed({2'b00, BASE_SPD}) - $signed({{2{adj[ADJ_W-1]}}, adj});

   // Datapath registers and outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_sat  <= '0;
         prev_err <= '0;
         p_term   <= '0;
         d_term   <= '0;
         lft_spd  <= '0;
         rght_spd <= '0;
         spd_vld  <= 1'b0;
         busy     <= 1'b0;
      end else begin
         busy    <= (next_state != IDLE);
         spd_vld <= 1'b0;
         if (!go) begin
            err_sat  <= '0;
            prev_err <= '0;
            p_term   <= '0;
            d_term   <= '0;
            lft_spd  <= '0;
            rght_spd <= '0;
         end else begin
            if (ld_err) err_sat <= sat_err(error);
            if (ld_p)   p_term  <= sat_term(prod);
            if (ld_d) begin
               d_term   <= sat_term(prod);
               prev_err <= err_sat;
            end
            if (ld_sum) begin
               lft_spd  <= clamp_spd(lft_raw);
               rght_spd <= clamp_spd(rght_raw);
               spd_vld  <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_pid_sequencer.sv
// Self-checking bench for pid_sequencer: constant vector table, hand-written corner sequences,
// and randomized samples checked against an integer-arithmetic PID model.
module tb_pid_sequencer;
`ifdef PID_I_TERM_EN
   localparam int LAT  = 4;
   localparam bit I_EN = 1'b1;
`else
   localparam int LAT  = 3;
   localparam bit I_EN = 1'b0;
`endif
   localparam int P_GAIN = 2;
   localparam int D_GAIN = 7;
   localparam int BASE   = 512;

   logic        clk = 1'b0;
   logic        rst, go, err_vld;
   logic [15:0] error;
   logic        busy, dropped, spd_vld;
   logic [11:0] lft_spd, rght_spd;

   int checks = 0;
   int errors = 0;

   pid_sequencer dut (
      .clk(clk), .rst(rst), .go(go), .err_vld(err_vld), .error(error),
      .busy(busy), .dropped(dropped), .spd_vld(spd_vld),
      .lft_spd(lft_spd), .rght_spd(rght_spd)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] err;
      bit          fresh;
      logic [11:0] l;
      logic [11:0] r;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic int clampi(input int x, input int lo, input int hi);
      return (x < lo) ? lo : ((x > hi) ? hi : x);
   endfunction

   task automatic model(input logic [15:0] e, inout int prev, inout int integ,
                        output int l, output int r);
      int es, p, i, d, pid, adj;
      es    = clampi(int'($signed(e)), -1024, 1023);
      p     = clampi(es * P_GAIN, -16384, 16383);
      integ = clampi(integ + es, -32768, 32767);
      i     = I_EN ? (integ >>> 4) : 0;
      d     = clampi(es - prev, -256, 255) * D_GAIN;
      prev  = es;
      pid   = clampi(p + i + d, -16384, 16383);
      adj   = pid >>> 3;
      l     = clampi(BASE + adj, 0, 4095);
      r     = clampi(BASE - adj, 0, 4095);
   endtask

   // Called at a negedge with the FSM idle; returns at the negedge where spd_vld is expected.
   task automatic send(input string nm, input logic [15:0] e, input logic [11:0] el,
                       input logic [11:0] er, input int drop_at);
      int bad;
      bad     = 0;
      err_vld = 1'b1;
      error   = e;
      #1 chk({nm, "_idle_drop"}, int'(dropped), 0);
      @(negedge clk);
      for (int k = 0; k < LAT; k++) begin
         err_vld = 1'b0;
         if (busy !== 1'b1 || spd_vld !== 1'b0) bad++;
         if (k == drop_at) begin
            err_vld = 1'b1;
            error   = 16'($urandom);
            #1 chk({nm, "_dropped"}, int'(dropped), 1);
         end
         @(negedge clk);
      end
      err_vld = 1'b0;
      chk({nm, "_busy_window"}, bad, 0);
      chk({nm, "_spd_vld"}, int'(spd_vld), 1);
      chk({nm, "_busy_end"}, int'(busy), 0);
      chk({nm, "_lft"}, int'(lft_spd), int'(el));
      chk({nm, "_rght"}, int'(rght_spd), int'(er));
   endtask

   task automatic fresh();
      go = 1'b0;
      @(negedge clk);
      go = 1'b1;
   endtask

   initial begin
      int prev_m, integ_m, el, er, d, bad;
      logic [15:0] e;

      rst = 1'b1; go = 1'b0; err_vld = 1'b0; error = '0;
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_dropped", int'(dropped), 0);
      chk("rst_spd_vld", int'(spd_vld), 0);
      chk("rst_lft", int'(lft_spd), 0);
      chk("rst_rght", int'(rght_spd), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      go  = 1'b1;
      @(negedge clk);

      vecs[0] = '{16'h0000, 1'b1, 12'h200, 12'h200};
      vecs[1] = '{16'h0040, 1'b1, 12'h248, 12'h1B8};
      if (I_EN) begin
         vecs[2] = '{16'h0040, 1'b0, 12'h211, 12'h1EF};
         vecs[3] = '{16'h7FFF, 1'b1, 12'h3E6, 12'h01A};
         vecs[4] = '{16'h8000, 1'b1, 12'h018, 12'h3E8};
         vecs[5] = '{16'h8000, 1'b0, 12'h0F0, 12'h310};
         vecs[6] = '{16'h0100, 1'b0, 12'h311, 12'h0EF};
      end else begin
         vecs[2] = '{16'h0040, 1'b0, 12'h210, 12'h1F0};
         vecs[3] = '{16'h7FFF, 1'b1, 12'h3DE, 12'h022};
         vecs[4] = '{16'h8000, 1'b1, 12'h020, 12'h3E0};
         vecs[5] = '{16'h8000, 1'b0, 12'h100, 12'h300};
         vecs[6] = '{16'h0100, 1'b0, 12'h31F, 12'h0E1};
      end
      for (int v = 0; v < 7; v++) begin
         if (vecs[v].fresh) fresh();
         send($sformatf("vec%0d", v), vecs[v].err, vecs[v].l, vecs[v].r, -1);
      end

      // Sample arriving in P_CALC is dropped; exactly one result follows
      fresh();
      send("drop_p", 16'h0040, 12'h248, 12'h1B8, 0);
      @(negedge clk);
      chk("drop_single_vld", int'(spd_vld), 0);
      chk("hold_lft", int'(lft_spd), 32'h248);

      // Abort in D_CALC with non-zero speeds and history
      send("pre_abort", 16'h0040, I_EN ? 12'h211 : 12'h210, I_EN ? 12'h1EF : 12'h1F0, -1);
      err_vld = 1'b1; error = 16'h0040;
      @(negedge clk);
      err_vld = 1'b0;
      repeat (LAT - 2) @(negedge clk);
      go = 1'b0;
      @(negedge clk);
      chk("abort_spd_vld", int'(spd_vld), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_lft", int'(lft_spd), 0);
      chk("abort_rght", int'(rght_spd), 0);
      go  = 1'b1;
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (spd_vld !== 1'b0) bad++;
      end
      chk("abort_no_result", bad, 0);
      send("post_abort", 16'h0040, 12'h248, 12'h1B8, -1);

      // Asynchronous reset in the middle of a computation
      err_vld = 1'b1; error = 16'h0040;
      @(negedge clk);
      err_vld = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_spd_vld", int'(spd_vld), 0);
      chk("midrst_lft", int'(lft_spd), 0);
      chk("midrst_rght", int'(rght_spd), 0);
      @(negedge clk);
      rst = 1'b0;
      send("post_rst", 16'h0000, 12'h200, 12'h200, -1);

      // Randomized samples against the reference model
      fresh();
      prev_m  = 0;
      integ_m = 0;
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 2))
            0:       e = 16'($urandom);
            1:       e = 16'($urandom_range(0, 400) - 200);
            default: e = 16'($urandom_range(900, 1100));
         endcase
         if ($urandom_range(0, 1) == 1) e = -e;
         model(e, prev_m, integ_m, el, er);
         d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LAT - 1)) : -1;
         send("rnd", e, 12'(el), 12'(er), d);
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            chk("rnd_hold_vld", int'(spd_vld), 0);
            chk("rnd_hold_lft", int'(lft_spd), el);
         end
         if ($urandom_range(0, 7) == 0) begin
            fresh();
            prev_m  = 0;
            integ_m = 0;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pid_sequencer.md
# pid_sequencer

Multi-cycle controller that sequences the PID steering datapath. It accepts IR error samples, computes the P, I and D terms one per cycle through a single shared signed multiplier, and produces saturated left/right motor speeds with a one-cycle valid strobe. It sits between the IR error front end and the motor drive.

## Interface
- P_COEFF, 6'sd2, signed proportional gain
- D_COEFF, 6'sd7, signed derivative gain
- BASE_SPD, 12'h200, unsigned base speed applied to both sides
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- go  in  1  enable; low aborts, clears history and forces speeds to 0
- err_vld  in  1  one-cycle strobe: `error` is meaningful
- error  in  16  signed IR error
- busy  out  1  high while a computation is in progress
- dropped  out  1  one-cycle pulse: `err_vld` arrived while busy and the sample was ignored
- spd_vld  out  1  one-cycle pulse: new `lft_spd`/`rght_spd`
- lft_spd  out  12  unsigned left speed
- rght_spd  out  12  unsigned right speed

## Operation
- FSM states: IDLE, P_CALC, I_CALC, D_CALC, SUM. Each non-IDLE state lasts exactly one cycle. SUM returns to IDLE.
- IDLE and `go & err_vld`: register err_sat and go to P_CALC. `err_vld` with `go` low is ignored, and `dropped` is not asserted.
- err_sat: saturate the 16-bit error to 11 bits signed, giving the range 0x3FF / 0x400.
- P_CALC: P_term = err_sat × P_COEFF (17 bits), saturated to 15 bits signed.
- I_CALC: integ is a 16-bit signed register.
  - integ ← integ + sext(err_sat), saturated at 0x7FFF / 0x8000.
  - I_term = sext(integ >>> 4).
- D_CALC: diff = err_sat − prev_err (12 bits), saturated to 9 bits signed (+255 / −256).
  - D_term = diff_sat × D_COEFF on the shared multiplier.
  - prev_err ← err_sat.
- SUM:
  - pid = P + I + D, computed in 17 bits and saturated to ±16383 / −16384.
  - adj = pid >>> 3.
  - lft = BASE_SPD + adj and rght = BASE_SPD − adj, each computed in 14 bits signed and clamped to [0, 4095].
  - Both are registered and `spd_vld` is set.
- The multiplier is shared: its operand mux selects (err_sat, P_COEFF) in P_CALC and (diff_sat, D_COEFF) in D_CALC. No second multiplier is allowed.
- `err_vld` while busy: `dropped` pulses in that cycle; the sample, integ and prev_err are unaffected.
- `go` low, in any state, registered on the next edge:
  - state returns to IDLE;
  - integ, prev_err and the speeds go to 0;
  - `spd_vld` is 0, and no result is emitted for an aborted sample.
- The first sample after `go` rises uses prev_err = 0.
- Speeds hold their last value between updates.

## Timing
- Reset: state IDLE; integ, prev_err and all internal registers 0; every output 0.
- Latency: `err_vld` sampled at edge N means `busy` is high for cycles N+1..N+4 and `spd_vld` is high in cycle N+5, with new speeds visible in that same cycle.
- Back-to-back operation: `err_vld` is accepted in the same cycle that `spd_vld` is high, because the FSM is already IDLE. Maximum throughput is one sample per 5 cycles.
- `busy` is a registered function of state, so it has no combinational path from inputs.

## Configuration
- PID_I_TERM_EN defined: full behaviour as above.
- PID_I_TERM_EN undefined:
  - I_CALC state and the integ register are removed and I_term = 0;
  - the FSM goes P_CALC→D_CALC;
  - `busy` lasts 3 cycles and `spd_vld` arrives at N+4.

## Test plan
All scenarios use the default parameters.
- Reset: assert `rst` mid-computation → immediately `busy`=0, `spd_vld`=0, lft/rght=0. After release with `go`=1, error=0x0000 → `spd_vld` at N+5, lft=rght=0x200.
- First sample error=0x0040 after `go` rise → P=128, I=4, D=448, adj=72; lft=0x248, rght=0x1B8 at N+5.
- Saturation, fresh history, error=0x7FFF → P=2046, I=63, D=1785 (diff clipped to 255), adj=486; lft=0x3E6, rght=0x01A. Fresh history, error=0x8000 → adj=−488; lft=0x018, rght=0x3E8.
- `err_vld` pulsed in the P_CALC cycle of a 0x0040 sample → `dropped`=1 for that cycle; result still lft=0x248 at N+5, and only one `spd_vld`.
- `go` dropped during D_CALC → no `spd_vld`; speeds 0 next cycle. `go` high, error=0x0040 again → lft=0x248 (prev_err and integ were cleared).
- Build without PID_I_TERM_EN, error=0x0040 → lft=0x248, rght=0x1B8 with `spd_vld` at N+4, `busy` high for exactly 3 cycles.
